password_generator: RTL and testbench

PASSWORD_GENERATOR -- requirements
Module: password_generator

---
 rtl/pwgen_pkg.sv | 23 ++
 rtl/pwgen_digit.sv | 40 ++++
 rtl/password_generator.sv | 144 ++++++++++++++
 tb/tb_password_generator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwgen_pkg.sv
// Shared types, charset constants and symbol-to-ASCII mapping
// for the password generator.
package pwgen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [5:0] RADIX_ALPHA = 6'd26;
    localparam logic [5:0] RADIX_ALNUM = 6'd36;
    localparam logic [7:0] ASCII_A     = 8'h61;
    localparam logic [7:0] ASCII_0     = 8'h30;

    function automatic logic [7:0] idx2ascii(input logic [5:0] idx);
        if (idx < RADIX_ALPHA)
            return ASCII_A + {2'b00, idx};
        return ASCII_0 + {2'b00, idx} - {2'b00, RADIX_ALPHA};
    endfunction

endpackage

// File: rtl/pwgen_digit.sv
// One odometer position: index register, add, radix compare
// and carry-out.
module pwgen_digit (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       step,
    input  logic [5:0] radix,
    input  logic [5:0] addend,
    input  logic [5:0] seed,
    output logic [5:0] nxt,
    output logic       carry
);

    logic [5:0] idx;
    logic [6:0] sum;
    logic [5:0] adv;
    logic [5:0] ld_val;

    assign sum    = {1'b0, idx} + {1'b0, addend};
    assign carry  = (sum >= {1'b0, radix});
    assign adv    = carry ? 6'(sum - {1'b0, radix}) : sum[5:0];
    assign ld_val = (seed >= radix) ? 6'd0 : seed;

    always_comb begin
        nxt = idx;
        if (load)
            nxt = ld_val;
        else if (step)
            nxt = adv;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            idx <= 6'd0;
        else
            idx <= nxt;
    end

endmodule

// File: rtl/password_generator.sv
// Odometer-style password candidate generator with valid/ready output.
// PWGEN_CHARSET_DIGITS_EN enables the radix-36 charset via digitMode.
module password_generator #(
    parameter int NUM_CHARS = 4,
    parameter int STRIDE_W  = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [NUM_CHARS*6-1:0] seed,
    input  logic [STRIDE_W-1:0]    increment,
    input  logic                   continuous,
    input  logic                   digitMode,
    input  logic                   ready,
    output logic                   valid,
    output logic [NUM_CHARS*8-1:0] password,
    output logic                   wrap,
    output logic                   busy
);

    import pwgen_pkg::*;

    state_t state;
    state_t state_n;

    logic [5:0]             radix_q;
    logic [5:0]             radix_ld;
    logic [5:0]             radix_eff;
    logic [5:0]             inc6;
    logic [NUM_CHARS-1:0]   cy;
    logic [NUM_CHARS*6-1:0] nxt_flat;
    logic [NUM_CHARS*8-1:0] pw_n;
    logic                   ld;
    logic                   step;
    logic                   pw_upd;
    logic                   wrap_n;
    logic                   valid_n;

`ifdef PWGEN_CHARSET_DIGITS_EN
    assign radix_ld = digitMode ? RADIX_ALNUM : RADIX_ALPHA;
`else
    logic unused_mode;
    assign unused_mode = digitMode;
    assign radix_ld    = RADIX_ALPHA;
`endif

    // The charset is captured in LOAD; digits must see it on that same edge.
    assign radix_eff = (state == LOAD) ? radix_ld : radix_q;
    assign inc6      = (increment == '0) ? 6'd1 : 6'(increment);
    assign busy      = (state == LOAD) || (state == RUN);

    for (genvar i = 0; i < NUM_CHARS; i++) begin : g_dig
        logic [5:0] add;
        if (i == 0) begin : g_lo
            assign add = inc6;
        end else begin : g_hi
            assign add = {5'd0, cy[i-1]};
        end
        pwgen_digit u_dig (
            .clock  (clock),
            .resetn (resetn),
            .load   (ld),
            .step   (step),
            .radix  (radix_eff),
            .addend (add),
            .seed   (seed[i*6 +: 6]),
            .nxt    (nxt_flat[i*6 +: 6]),
            .carry  (cy[i])
        );
        assign pw_n[i*8 +: 8] = idx2ascii(nxt_flat[i*6 +: 6]);
    end

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        step    = 1'b0;
        pw_upd  = 1'b0;
        wrap_n  = 1'b0;
        valid_n = valid;
        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (start)
                    state_n = LOAD;
            end
            LOAD: begin
                ld      = 1'b1;
                pw_upd  = 1'b1;
                valid_n = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (start) begin
                    valid_n = 1'b0;
                    state_n = LOAD;
                end else if (valid && ready) begin
                    if (cy[NUM_CHARS-1]) begin
                        wrap_n = 1'b1;
                        if (continuous) begin
                            ld     = 1'b1;
                            pw_upd = 1'b1;
                        end else begin
                            valid_n = 1'b0;
                            state_n = DONE;
                        end
                    end else begin
                        step   = 1'b1;
                        pw_upd = 1'b1;
                    end
                end
            end
            DONE: begin
                valid_n = 1'b0;
                if (start)
                    state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            radix_q  <= RADIX_ALPHA;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            password <= '0;
        end else begin
            if (state == LOAD)
                radix_q <= radix_ld;
            valid <= valid_n;
            wrap  <= wrap_n;
            if (pw_upd)
                password <= pw_n;
        end
    end

endmodule

// File: tb/tb_password_generator.sv
// Scoreboard bench for password_generator (NUM_CHARS=2).
module tb_password_generator;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [11:0] seed;
    logic [2:0]  increment;
    logic        continuous;
    logic        digitMode;
    logic        ready;
    logic        valid;
    logic [15:0] password;
    logic        wrap;
    logic        busy;

    password_generator #(.NUM_CHARS(2), .STRIDE_W(3)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .seed       (seed),
        .increment  (increment),
        .continuous (continuous),
        .digitMode  (digitMode),
        .ready      (ready),
        .valid      (valid),
        .password   (password),
        .wrap       (wrap),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } obs_t;

    obs_t        obsq[$];
    logic [15:0] expq[$];
    int          n_vec = 0;
    int          n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] r);
        obs_t t;
        t.name = n;
        t.act  = a;
        t.req  = r;
        obsq.push_back(t);
    endtask

    // monitor: drains observations and checks every accepted password
    always @(negedge clock) begin
        obs_t        o;
        logic [15:0] e;
        while (obsq.size() > 0) begin
            o = obsq.pop_front();
            n_vec++;
            if (o.act !== o.req) begin
                n_err++;
                $display("FAIL %s: got %h want %h", o.name, o.act, o.req);
            end
        end
        if (resetn === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            n_vec++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL accept: got %h want none queued", password);
            end else begin
                e = expq.pop_front();
                if (password !== e) begin
                    n_err++;
                    $display("FAIL accept: got %h want %h", password, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [11:0] s);
        @(posedge clock); #1;
        seed  = s;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic accept(input int n);
        ready = 1'b1;
        repeat (n) @(posedge clock);
        #1 ready = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        seed       = '0;
        increment  = 3'd1;
        continuous = 1'b0;
        digitMode  = 1'b0;
        ready      = 1'b0;
        #3;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pw", 32'(password), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wrap", 32'(wrap), 0);
        @(posedge clock); #1 resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_valid", 32'(valid), 0);

        // alphabetic wrap: "aa".."za" then "ab"
        do_start(12'd0);
        chk("load_valid", 32'(valid), 1);
        chk("load_busy", 32'(busy), 1);
        for (int k = 0; k < 26; k++)
            expq.push_back({8'h61, 8'(8'h61 + k)});
        expq.push_back(16'h6261);
        accept(27);
        chk("after_wrap_pw", 32'(password), 32'h6262);

        // stride carry: 'y' + 3 -> 'b' with carry
        increment = 3'd3;
        do_start({6'd0, 6'd24});
        chk("stride_seed", 32'(password), 32'h6179);
        expq.push_back(16'h6179);
        accept(1);
        chk("stride_pw", 32'(password), 32'h6262);

        // stall
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            chk("stall_pw", 32'(password), 32'h6262);
            chk("stall_valid", 32'(valid), 1);
        end
        expq.push_back(16'h6262);
        accept(1);
        chk("stall_adv", 32'(password), 32'h6265);
        @(posedge clock); #1;
        chk("stall_once", 32'(password), 32'h6265);

        // exhaustion, non-continuous
        increment = 3'd0;
        do_start({6'd25, 6'd25});
        chk("zz_seed", 32'(password), 32'h7a7a);
        expq.push_back(16'h7a7a);
        ready = 1'b1;
        @(posedge clock); #1 ready = 1'b0;
        chk("done_wrap", 32'(wrap), 1);
        chk("done_valid", 32'(valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_pw", 32'(password), 32'h7a7a);
        @(posedge clock); #1;
        chk("done_wrap_end", 32'(wrap), 0);

        // exhaustion, continuous
        continuous = 1'b1;
        do_start({6'd25, 6'd25});
        expq.push_back(16'h7a7a);
        ready = 1'b1;
        @(posedge clock); #1 ready = 1'b0;
        chk("cont_wrap", 32'(wrap), 1);
        chk("cont_valid", 32'(valid), 1);
        chk("cont_busy", 32'(busy), 1);
        chk("cont_pw", 32'(password), 32'h7a7a);
        @(posedge clock); #1;
        chk("cont_wrap_end", 32'(wrap), 0);
        continuous = 1'b0;

        // out-of-range seed index loads as 0
        increment = 3'd1;
        do_start({6'd30, 6'd2});
        chk("clamp_pw", 32'(password), 32'h6163);

        // start beats a same-cycle handshake
        seed  = {6'd0, 6'd5};
        start = 1'b1;
        ready = 1'b1;
        expq.push_back(16'h6163);
        @(posedge clock); #1;
        start = 1'b0;
        ready = 1'b0;
        chk("prio_valid", 32'(valid), 0);
        chk("prio_busy", 32'(busy), 1);
        chk("prio_hold", 32'(password), 32'h6163);
        @(posedge clock); #1;
        chk("prio_pw", 32'(password), 32'h6166);
        chk("prio_valid2", 32'(valid), 1);

        // asynchronous reset mid-run
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_pw", 32'(password), 0);
        chk("arst_busy", 32'(busy), 0);
        @(posedge clock); #1 resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1 chk("arst_idle", 32'(busy), 0);

`ifdef PWGEN_CHARSET_DIGITS_EN
        digitMode = 1'b1;
        do_start({6'd0, 6'd25});
        chk("dig_seed", 32'(password), 32'h617a);
        expq.push_back(16'h617a);
        accept(1);
        chk("dig_zero", 32'(password), 32'h6130);
        do_start({6'd0, 6'd35});
        chk("dig_nine", 32'(password), 32'h6139);
        expq.push_back(16'h6139);
        accept(1);
        chk("dig_carry", 32'(password), 32'h6261);
        digitMode = 1'b0;
`endif

        repeat (2) @(negedge clock);
        #1 chk("leftover_expected", 32'(expq.size()), 0);
        repeat (2) @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
